// File: rtl/lfsr_addr_gen.sv
// lfsr_addr_gen: pseudo-random address sequencer.
// A Galois LFSR (right-shift) is seeded at start. Each LFSR value is zero-extended,
// shifted left by a latched amount and added to a latched base. The resulting
// address stream goes out over a valid/ready handshake.
// Optional feature macro: LFSR_ADDR_PERIOD_DET_EN. When it is defined, period_hit
// pulses when the LFSR returns to its seed. When it is not defined, period_hit is 0.
// LFSR_WIDTH must not exceed ADDR_WIDTH.

module lfsr_addr_gen #(
    parameter int ADDR_WIDTH = 32,
    parameter int LFSR_WIDTH = 16,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic                  cfg_start,
    input  logic                  cfg_abort,
    input  logic [LFSR_WIDTH-1:0] cfg_seed,
    input  logic [LFSR_WIDTH-1:0] cfg_taps,
    input  logic [ADDR_WIDTH-1:0] cfg_base,
    input  logic [4:0]            cfg_shift,
    input  logic [CNT_WIDTH-1:0]  cfg_count,
    output logic [ADDR_WIDTH-1:0] m_addr,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_WIDTH-1:0]  issued_cnt,
    output logic [LFSR_WIDTH-1:0] lfsr_state,
    output logic                  period_hit
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    // Configuration captured at start. Later changes on cfg_* inputs are ignored.
    logic [LFSR_WIDTH-1:0] taps_q;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [4:0]            shift_q;
    logic [CNT_WIDTH-1:0]  remaining;

    logic                  hs;
    logic                  start_acc;
    logic                  last_hs;
    logic [LFSR_WIDTH-1:0] seed_eff;
    logic [LFSR_WIDTH-1:0] lfsr_nxt;

    // base + (zero-extended value << shift), wrapping at ADDR_WIDTH bits
    function automatic logic [ADDR_WIDTH-1:0] addr_of(
        input logic [ADDR_WIDTH-1:0] b,
        input logic [LFSR_WIDTH-1:0] v,
        input logic [4:0]            sh
    );
        logic [ADDR_WIDTH-1:0] ext;
        ext = ADDR_WIDTH'(v);
        return b + (ext << sh);
    endfunction

    // Handshake, start qualification, seed substitution and the Galois step
    always_comb begin
        hs        = m_valid && m_ready;
        // Start is honoured only outside RUN. An abort in the same cycle wins.
        start_acc = cfg_start && !cfg_abort && (state != S_RUN);
        last_hs   = hs && (remaining == CNT_WIDTH'(1));
        // An all-zero seed would lock the LFSR at zero, so use 1 instead.
        seed_eff  = (cfg_seed == '0) ? LFSR_WIDTH'(1) : cfg_seed;
        lfsr_nxt  = (lfsr_state >> 1) ^ (lfsr_state[0] ? taps_q : '0);
    end

    // FSM state register
    always_ff @(posedge ACLK) begin
        if (ARESET) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // FSM next-state logic. Abort takes priority in every state.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (cfg_abort)      state_nxt = S_IDLE;
                else if (start_acc) state_nxt = (cfg_count == '0) ? S_DONE : S_RUN;
            end
            S_RUN: begin
                if (cfg_abort)    state_nxt = S_IDLE;
                else if (last_hs) state_nxt = S_DONE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy = (state == S_RUN);
    end

    // Datapath: config latch, LFSR, address register, counters, valid and done
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            taps_q     <= '0;
            base_q     <= '0;
            shift_q    <= '0;
            remaining  <= '0;
            lfsr_state <= '0;
            m_addr     <= '0;
            issued_cnt <= '0;
            m_valid    <= 1'b0;
            done       <= 1'b0;
        end else begin
            if (start_acc) begin
                taps_q     <= cfg_taps;
                base_q     <= cfg_base;
                shift_q    <= cfg_shift;
                remaining  <= cfg_count;
                lfsr_state <= seed_eff;
                m_addr     <= addr_of(cfg_base, seed_eff, cfg_shift);
                issued_cnt <= '0;
            end else if (hs) begin
                // A handshake still counts when it coincides with an abort.
                lfsr_state <= lfsr_nxt;
                m_addr     <= addr_of(base_q, lfsr_nxt, shift_q);
                remaining  <= remaining - CNT_WIDTH'(1);
                if (issued_cnt != '1)
                    issued_cnt <= issued_cnt + CNT_WIDTH'(1);
            end
            // Valid tracks RUN. It falls only after the last handshake, on abort or on reset.
            m_valid <= (state_nxt == S_RUN);
            done    <= (state_nxt == S_DONE);
        end
    end

`ifdef LFSR_ADDR_PERIOD_DET_EN
    logic [LFSR_WIDTH-1:0] seed_q;

    // Keep the post-substitution seed and flag the advance that returns to it
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            seed_q     <= '0;
            period_hit <= 1'b0;
        end else begin
            if (start_acc) seed_q <= seed_eff;
            period_hit <= hs && !start_acc && (lfsr_nxt == seed_q);
        end
    end
`else
    // Period detection is not built
    always_comb begin
        period_hit = 1'b0;
    end
`endif

endmodule

// File: tb/tb_lfsr_addr_gen.sv
// Self-checking bench for lfsr_addr_gen.
// A scoreboard queue holds the expected addresses, which are pushed at start.
// Each handshake seen at the falling edge pops one entry and compares it.
module tb_lfsr_addr_gen;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic        cfg_start, cfg_abort;
    logic [15:0] cfg_seed, cfg_taps;
    logic [31:0] cfg_base;
    logic [4:0]  cfg_shift;
    logic [31:0] cfg_count;
    logic [31:0] m_addr;
    logic        m_valid, m_ready;
    logic        busy, done;
    logic [31:0] issued_cnt;
    logic [15:0] lfsr_state;
    logic        period_hit;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];

    lfsr_addr_gen dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .cfg_start(cfg_start), .cfg_abort(cfg_abort),
        .cfg_seed(cfg_seed), .cfg_taps(cfg_taps), .cfg_base(cfg_base),
        .cfg_shift(cfg_shift), .cfg_count(cfg_count),
        .m_addr(m_addr), .m_valid(m_valid), .m_ready(m_ready),
        .busy(busy), .done(done), .issued_cnt(issued_cnt),
        .lfsr_state(lfsr_state), .period_hit(period_hit)
    );

    always #5 ACLK = ~ACLK;

    task automatic tick;
        @(posedge ACLK);
        #1;
    endtask

    // Reference model: Galois right-shift step and address formation
    function automatic logic [15:0] m_adv(input logic [15:0] s, input logic [15:0] t);
        return (s >> 1) ^ (s[0] ? t : 16'h0);
    endfunction

    task automatic push_seq(input logic [15:0] seed, input logic [15:0] taps,
                            input logic [31:0] base, input int sh, input int n);
        logic [15:0] s;
        logic [31:0] ext;
        s = (seed == 16'h0) ? 16'h1 : seed;
        for (int i = 0; i < n; i++) begin
            ext = {16'h0, s};
            exp_q.push_back(base + (ext << sh));
            s = m_adv(s, taps);
        end
    endtask

    task automatic cfg(input logic [15:0] seed, input logic [31:0] count);
        cfg_seed  = seed;
        cfg_taps  = 16'hB400;
        cfg_base  = 32'h4000_0000;
        cfg_shift = 5'd2;
        cfg_count = count;
    endtask

    task automatic test_reset;
        ARESET = 1'b1;
        tick; tick;
        @(negedge ACLK);
        n_cmp++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", m_valid); end
        n_cmp++; if (m_addr !== 32'h0) begin n_err++; $display("FAIL reset_addr got %h want 0", m_addr); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", done); end
        n_cmp++; if (issued_cnt !== 32'h0) begin n_err++; $display("FAIL reset_issued got %0d want 0", issued_cnt); end
        n_cmp++; if (lfsr_state !== 16'h0) begin n_err++; $display("FAIL reset_lfsr got %h want 0", lfsr_state); end
        n_cmp++; if (period_hit !== 1'b0) begin n_err++; $display("FAIL reset_period got %b want 0", period_hit); end
        ARESET = 1'b0;
        tick;
    endtask

    task automatic test_basic;
        int g;
        logic [31:0] a;
        exp_q.delete();
        exp_q.push_back(32'h4000_0004);
        exp_q.push_back(32'h4002_D000);
        exp_q.push_back(32'h4001_6800);
        cfg(16'h0001, 32'd3);
        m_ready = 1'b1; cfg_start = 1'b1;
        tick;
        cfg_start = 1'b0;
        g = 0;
        // One address per cycle: valid must be high in every sampled cycle.
        while (exp_q.size() > 0 && g < 20) begin
            @(negedge ACLK);
            n_cmp++;
            if (m_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid got %b want 1", m_valid); end
            else begin
                a = exp_q.pop_front();
                n_cmp++; if (m_addr !== a) begin n_err++; $display("FAIL basic_addr got %h want %h", m_addr, a); end
            end
            tick; g++;
        end
        @(negedge ACLK);
        n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL basic_done got %b want 1", done); end
        n_cmp++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL basic_valid_end got %b want 0", m_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL basic_busy got %b want 0", busy); end
        n_cmp++; if (issued_cnt !== 32'd3) begin n_err++; $display("FAIL basic_issued got %0d want 3", issued_cnt); end
        n_cmp++; if (lfsr_state !== 16'h2D00) begin n_err++; $display("FAIL basic_lfsr got %h want 2d00", lfsr_state); end
    endtask

    task automatic test_zero_seed;
        int g;
        logic [31:0] a;
        exp_q.delete();
        exp_q.push_back(32'h4000_0004);
        exp_q.push_back(32'h4002_D000);
        cfg(16'h0000, 32'd2);
        m_ready = 1'b1; cfg_start = 1'b1;
        tick;
        cfg_start = 1'b0;
        g = 0;
        while (exp_q.size() > 0 && g < 20) begin
            @(negedge ACLK);
            if (m_valid && m_ready) begin
                a = exp_q.pop_front();
                n_cmp++; if (m_addr !== a) begin n_err++; $display("FAIL zseed_addr got %h want %h", m_addr, a); end
            end
            tick; g++;
        end
        n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL zseed_timeout left %0d want 0", exp_q.size()); end
        @(negedge ACLK);
        n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL zseed_done got %b want 1", done); end
    endtask

    task automatic test_zero_count;
        cfg(16'h0001, 32'd0);
        m_ready = 1'b1; cfg_start = 1'b1;
        tick;
        cfg_start = 1'b0;
        @(negedge ACLK);
        n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL zcnt_done got %b want 1", done); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL zcnt_busy got %b want 0", busy); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL zcnt_valid got %b want 0", m_valid); end
            tick;
            @(negedge ACLK);
        end
        n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL zcnt_sticky got %b want 1", done); end
        // An abort clears done.
        cfg_abort = 1'b1;
        tick;
        cfg_abort = 1'b0;
        @(negedge ACLK);
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL zcnt_abort_done got %b want 0", done); end
    endtask

    task automatic test_backpressure;
        int g;
        logic [31:0] a;
        exp_q.delete();
        cfg(16'h0001, 32'd6);
        push_seq(16'h0001, 16'hB400, 32'h4000_0000, 2, 6);
        m_ready = 1'b0; cfg_start = 1'b1;
        tick;
        cfg_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge ACLK);
            n_cmp++; if (m_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid got %b want 1", m_valid); end
            n_cmp++; if (m_addr !== 32'h4000_0004) begin n_err++; $display("FAIL bp_addr got %h want 40000004", m_addr); end
            n_cmp++; if (lfsr_state !== 16'h0001) begin n_err++; $display("FAIL bp_lfsr got %h want 0001", lfsr_state); end
            // A start issued during RUN, with a different seed, must be ignored.
            if (i == 2) begin cfg_start = 1'b1; cfg_seed = 16'h1234; end
            tick;
            cfg_start = 1'b0;
        end
        g = 0;
        while (exp_q.size() > 0 && g < 100) begin
            m_ready = 1'($urandom_range(0, 1));
            @(negedge ACLK);
            n_cmp++; if (m_valid !== 1'b1) begin n_err++; $display("FAIL bp_drop got %b want 1", m_valid); end
            if (m_valid && m_ready) begin
                a = exp_q.pop_front();
                n_cmp++; if (m_addr !== a) begin n_err++; $display("FAIL bp_seq got %h want %h", m_addr, a); end
            end
            tick; g++;
        end
        n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL bp_timeout left %0d want 0", exp_q.size()); end
        @(negedge ACLK);
        n_cmp++; if (issued_cnt !== 32'd6) begin n_err++; $display("FAIL bp_issued got %0d want 6", issued_cnt); end
        m_ready = 1'b1;
    endtask

    task automatic test_abort;
        logic [31:0] a;
        exp_q.delete();
        cfg(16'h0001, 32'd10);
        push_seq(16'h0001, 16'hB400, 32'h4000_0000, 2, 10);
        m_ready = 1'b1; cfg_start = 1'b1;
        tick;
        cfg_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge ACLK);
            a = exp_q.pop_front();
            n_cmp++; if (m_addr !== a || m_valid !== 1'b1) begin n_err++; $display("FAIL abort_addr got %h/%b want %h/1", m_addr, m_valid, a); end
            tick;
        end
        m_ready = 1'b0; cfg_abort = 1'b1;
        tick;
        cfg_abort = 1'b0;
        @(negedge ACLK);
        n_cmp++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL abort_valid got %b want 0", m_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort_busy got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL abort_done got %b want 0", done); end
        n_cmp++; if (issued_cnt !== 32'd3) begin n_err++; $display("FAIL abort_issued got %0d want 3", issued_cnt); end
        exp_q.delete();
        // Start and abort in the same cycle: the block stays idle.
        cfg(16'h0001, 32'd5);
        cfg_start = 1'b1; cfg_abort = 1'b1;
        tick;
        cfg_start = 1'b0; cfg_abort = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge ACLK);
            n_cmp++; if (busy !== 1'b0 || m_valid !== 1'b0) begin n_err++; $display("FAIL abstart_idle got busy=%b valid=%b want 0/0", busy, m_valid); end
            tick;
        end
        m_ready = 1'b1;
    endtask

    task automatic test_reset_mid_run;
        int g;
        logic [31:0] a;
        exp_q.delete();
        cfg(16'h0001, 32'd5);
        push_seq(16'h0001, 16'hB400, 32'h4000_0000, 2, 5);
        m_ready = 1'b1; cfg_start = 1'b1;
        tick;
        cfg_start = 1'b0;
        tick; tick;
        ARESET = 1'b1;
        tick;
        ARESET = 1'b0;
        @(negedge ACLK);
        n_cmp++; if (m_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0)
            begin n_err++; $display("FAIL rst_mid_ctl got v=%b b=%b d=%b want 0", m_valid, busy, done); end
        n_cmp++; if (issued_cnt !== 32'h0 || lfsr_state !== 16'h0 || m_addr !== 32'h0)
            begin n_err++; $display("FAIL rst_mid_data got %0d/%h/%h want 0", issued_cnt, lfsr_state, m_addr); end
        tick;
        cfg_start = 1'b1;
        tick;
        cfg_start = 1'b0;
        g = 0;
        while (exp_q.size() > 0 && g < 30) begin
            @(negedge ACLK);
            if (m_valid && m_ready) begin
                a = exp_q.pop_front();
                n_cmp++; if (m_addr !== a) begin n_err++; $display("FAIL rst_restart got %h want %h", m_addr, a); end
            end
            tick; g++;
        end
        n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL rst_timeout left %0d want 0", exp_q.size()); end
        @(negedge ACLK);
        n_cmp++; if (done !== 1'b1 || issued_cnt !== 32'd5) begin n_err++; $display("FAIL rst_end got d=%b n=%0d want 1/5", done, issued_cnt); end
    endtask

    task automatic test_period;
        int g, hs_done, hits, hit_at, bad;
        logic [31:0] a;
        exp_q.delete();
        cfg(16'h0001, 32'd65536);
        push_seq(16'h0001, 16'hB400, 32'h4000_0000, 2, 65536);
        m_ready = 1'b1; cfg_start = 1'b1;
        tick;
        cfg_start = 1'b0;
        g = 0; hs_done = 0; hits = 0; hit_at = -1; bad = 0;
        while (exp_q.size() > 0 && g < 70000) begin
            @(negedge ACLK);
            if (period_hit) begin hits++; hit_at = hs_done; end
            if (m_valid && m_ready) begin
                a = exp_q.pop_front();
                hs_done++;
                if (m_addr !== a && bad < 3) begin
                    bad++; n_err++; n_cmp++;
                    $display("FAIL period_addr #%0d got %h want %h", hs_done, m_addr, a);
                end
            end
            tick; g++;
        end
        n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL period_timeout left %0d want 0", exp_q.size()); end
        @(negedge ACLK);
        if (period_hit) begin hits++; hit_at = hs_done; end
        n_cmp++; if (hs_done != 65536) begin n_err++; $display("FAIL period_count got %0d want 65536", hs_done); end
`ifdef LFSR_ADDR_PERIOD_DET_EN
        n_cmp++; if (hits != 1) begin n_err++; $display("FAIL period_hits got %0d want 1", hits); end
        n_cmp++; if (hit_at != 65535) begin n_err++; $display("FAIL period_at got %0d want 65535", hit_at); end
`else
        n_cmp++; if (hits != 0) begin n_err++; $display("FAIL period_off got %0d want 0", hits); end
`endif
        n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL period_done got %b want 1", done); end
    endtask

    initial begin
        ARESET = 1'b1; cfg_start = 1'b0; cfg_abort = 1'b0; m_ready = 1'b0;
        cfg_seed = '0; cfg_taps = '0; cfg_base = '0; cfg_shift = '0; cfg_count = '0;
        test_reset();
        test_basic();
        test_zero_seed();
        test_zero_count();
        test_backpressure();
        test_abort();
        test_reset_mid_run();
        test_period();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
